// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared writeback-select and load funct3 encodings
package riscv_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational byte/halfword extraction and extension of a load word
module load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        // Halfword loads ignore offset[0]; misalignment is not trapped here
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = i_word;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load alignment and retire counter
// Optional WB_BYPASS_EN adds write-then-read forwarding onto two register read ports.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 m_valid,
    input  logic                 m_reg_write,
    input  logic [4:0]           m_rd_addr,
    input  logic [2:0]           m_funct3,
    input  logic [1:0]           m_wb_sel,
    input  logic [31:0]          m_alu_result,
    input  logic [31:0]          m_load_word,
    input  logic [31:0]          m_pc_plus4,
`ifdef WB_BYPASS_EN
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    input  logic [31:0]          rs1_rdata,
    input  logic [31:0]          rs2_rdata,
    output logic [31:0]          rs1_fwd,
    output logic [31:0]          rs2_fwd,
`endif
    output logic                 rf_we,
    output logic [4:0]           rf_rd_addr,
    output logic [31:0]          rf_rd_data,
    output logic                 wb_valid,
    output logic [INSTRET_W-1:0] instret
);

    logic                 r_wb_valid;
    logic                 r_fresh;
    logic                 r_reg_write;
    logic [4:0]           r_rd_addr;
    logic [31:0]          r_rd_data;
    logic [INSTRET_W-1:0] r_instret;

    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;
    logic        w_retire;

    load_align u_load_align (
        .i_funct3 (m_funct3),
        .i_offset (m_alu_result[1:0]),
        .i_word   (m_load_word),
        .o_data   (w_load_data)
    );

    always_comb begin
        w_wb_data = m_alu_result;
        case (m_wb_sel)
            WB_SEL_LOAD: w_wb_data = w_load_data;
            WB_SEL_PC4:  w_wb_data = m_pc_plus4;
            default:     w_wb_data = m_alu_result;
        endcase
    end

    // fresh limits each instruction to one write and one count while stalled
    assign w_retire = r_wb_valid & r_fresh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid  <= 1'b0;
            r_fresh     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd_addr   <= 5'd0;
            r_rd_data   <= 32'd0;
            r_instret   <= '0;
        end else begin
            if (w_retire)
                r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
            if (flush) begin
                r_wb_valid <= 1'b0;
                r_fresh    <= 1'b0;
            end else if (!stall) begin
                r_wb_valid  <= m_valid;
                r_fresh     <= m_valid;
                r_reg_write <= m_reg_write;
                r_rd_addr   <= m_rd_addr;
                r_rd_data   <= w_wb_data;
            end else begin
                r_fresh <= 1'b0;
            end
        end
    end

    assign rf_we      = w_retire & r_reg_write & (r_rd_addr != 5'd0);
    assign rf_rd_addr = r_rd_addr;
    assign rf_rd_data = r_rd_data;
    assign wb_valid   = r_wb_valid;
    assign instret    = r_instret;

`ifdef WB_BYPASS_EN
    assign rs1_fwd = (rf_we && rs1_addr != 5'd0 && rs1_addr == r_rd_addr) ? r_rd_data : rs1_rdata;
    assign rs2_fwd = (rf_we && rs2_addr != 5'd0 && rs2_addr == r_rd_addr) ? r_rd_data : rs2_rdata;
`endif

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter INSTRET_W, default 64, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports stall input 1 (hold stage) and flush input 1 (kill stage contents).
REQ-005 SHALL have ports m_valid input 1 and m_reg_write input 1 (MEM-side instruction valid, writes rd).
REQ-006 SHALL have ports m_rd_addr input 5 and m_funct3 input 3 (load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
REQ-007 SHALL have port m_wb_sel input 2, writeback source: 00 ALU, 01 load, 10 PC+4, 11 treated as 00.
REQ-008 SHALL have ports m_alu_result, m_load_word and m_pc_plus4, each input 32 (m_load_word is the raw word-aligned memory read).
REQ-009 SHALL have outputs rf_we 1, rf_rd_addr 5 and rf_rd_data 32, driving the register-file write port.
REQ-010 SHALL have outputs wb_valid 1 and instret INSTRET_W.

Function
REQ-011 SHALL capture all m_* inputs on the rising clk edge when stall=0 and flush=0; wb_valid <= m_valid.
REQ-012 SHALL compute the final load value before the register, so rf_rd_data is already final (one-cycle latency from MEM to rf_*).
REQ-013 SHALL take the byte offset from m_alu_result[1:0]: lb/lbu select byte[offset]; lh/lhu select halfword[offset[1]] (offset[0] ignored); lw ignores the offset.
REQ-014 SHALL sign-extend lb/lh and zero-extend lbu/lhu; undefined funct3 values SHALL behave as lw.
REQ-015 SHALL hold all stage registers when stall=1 and flush=0.
REQ-016 SHALL clear wb_valid on the edge where flush=1; flush SHALL override stall.
REQ-017 SHALL keep an internal fresh flag: it is set when a valid instruction is captured and cleared after that instruction's first cycle in the stage.
REQ-018 SHALL drive rf_we = wb_valid & fresh & reg_write & (rd != 0), so a stalled instruction writes the register file exactly once.
REQ-019 SHALL increment instret by 1 in each cycle where wb_valid & fresh is true, wrapping modulo 2^INSTRET_W.

Reset
REQ-020 SHALL, on rst=1 and asynchronously, force wb_valid=0, fresh=0, rf_we=0, rf_rd_addr=0, rf_rd_data=0 and instret=0.
REQ-021 SHALL discard any instruction in flight at reset, with no write and no count; the first capture SHALL occur on the first edge after rst deasserts.

Configuration
REQ-022 SHALL, when WB_BYPASS_EN is defined, add inputs rs1_addr 5, rs2_addr 5, rs1_rdata 32 and rs2_rdata 32, plus outputs rs1_fwd 32 and rs2_fwd 32.
REQ-023 SHALL, with WB_BYPASS_EN defined, drive rsN_fwd = rf_rd_data when rf_we=1 and rf_rd_addr==rsN_addr!=0, else rsN_rdata (write-then-read bypass, combinational).
REQ-024 SHALL, without WB_BYPASS_EN, omit those ports and bypass logic entirely.

Structure
REQ-025 SHALL place the wb_sel encodings and the load funct3 constants in a shared package, riscv_pkg.
REQ-026 SHALL implement the load extraction/extension in one sub-module, load_align (purely combinational).

Verification
REQ-027 SHALL cover: lw, m_load_word=0x80FF7F01, offset 0 -> rf_rd_data=0x80FF7F01, rf_we=1 one cycle after capture.
REQ-028 SHALL cover: lb at offset 3 and lbu at offset 3, same word -> 0xFFFFFF80 and 0x00000080; lh at offset 2 -> 0xFFFF80FF.
REQ-029 SHALL cover: a valid write to rd=0 -> rf_we=0 while instret still increments.
REQ-030 SHALL cover: valid ALU op (rd=5, 0x1234) with stall held 3 cycles -> rf_we high for 1 cycle only, instret +1.
REQ-031 SHALL cover: flush and stall asserted together with a valid instruction -> wb_valid=0 next cycle, no write, instret unchanged.
REQ-032 SHALL cover: rst asserted mid-stream -> all outputs 0 immediately; with WB_BYPASS_EN, rf write to x7 and rs1_addr=7 -> rs1_fwd=rf_rd_data.
